// File: rtl/pc_seq_unit.sv
// Program-counter sequencer for the multi-cycle core: branches (with operand-settle wait),
// jumps, register-indirect jumps, stall and terminal halt. Optional link strobe: PC_LINK_EN.
module pc_seq_unit #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BR_WAIT   = 2,
  parameter int HALT_ADDR = 2**ADDR_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_fetch,
  input  logic              enable_mem,
  input  logic              stall,
  input  logic [31:0]       ir,
  input  logic [DATA_W-1:0] rs_t,
  input  logic [DATA_W-1:0] rs_a,
  output logic [ADDR_W-1:0] address,
  output logic              is_branch,
  output logic              taken,
  output logic              halted,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [5:0] OP_BR  = 6'b100110;
  localparam logic [5:0] OP_JMP = 6'b100100;
  localparam logic [5:0] OP_JR  = 6'b100101;

  localparam logic [2:0]        WAIT_N = 3'(BR_WAIT);
  localparam logic [ADDR_W-1:0] HALT_A = ADDR_W'(HALT_ADDR);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  logic [1:0]        state, state_nxt;
  logic [2:0]        count, count_nxt;
  logic [ADDR_W-1:0] address_nxt;
  logic              taken_nxt;
  logic              link_we_nxt;
  logic [ADDR_W-1:0] link_addr_q, link_addr_nxt;

  logic [5:0]        op;
  logic              adv;
  logic              br_cond;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jmp_off;
  logic [ADDR_W-1:0] br_target;
  logic              unused_ir;

  assign op  = ir[30:25];
  assign adv = enable_fetch & enable_mem & ~stall & (state != ST_HALT);

  // Offsets are sign-extended, doubled, then truncated to the address width.
  assign br_off  = ADDR_W'($signed(ir[13:0])) << 1;
  assign jmp_off = ADDR_W'($signed(ir[23:0])) << 1;

  assign br_cond   = ir[14] ? (rs_t != rs_a) : (rs_t == rs_a);
  assign br_target = br_cond ? (address + br_off) : (address + ONE);

  assign unused_ir = ^{ir[31], ir[24]};

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    address_nxt   = address;
    taken_nxt     = 1'b0;
    link_we_nxt   = 1'b0;
    link_addr_nxt = link_addr_q;
    if (adv) begin
      // Reaching the halt address wins over whatever the instruction says.
      if (address == HALT_A) begin
        state_nxt = ST_HALT;
      end else begin
        case (state)
          ST_RUN: begin
            case (op)
              OP_BR: begin
                if (WAIT_N == 3'd0) begin
                  address_nxt = br_target;
                  taken_nxt   = br_cond;
                end else begin
                  state_nxt = ST_WAIT;
                  count_nxt = 3'd1;
                end
              end
              OP_JMP: begin
                address_nxt = address + jmp_off;
                taken_nxt   = 1'b1;
`ifdef PC_LINK_EN
                if (ir[24]) begin
                  link_we_nxt   = 1'b1;
                  link_addr_nxt = address + ONE;
                end
`endif
              end
              OP_JR: begin
                address_nxt = rs_a[ADDR_W-1:0];
                taken_nxt   = 1'b1;
              end
              default: address_nxt = address + ONE;
            endcase
          end
          ST_WAIT: begin
            if (count == WAIT_N) begin
              address_nxt = br_target;
              taken_nxt   = br_cond;
              count_nxt   = 3'd0;
              state_nxt   = ST_RUN;
            end else begin
              count_nxt = count + 3'd1;
            end
          end
          default: state_nxt = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      count       <= 3'd0;
      address     <= '1;
      taken       <= 1'b0;
      link_we_nxt_q_clear();
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      address     <= address_nxt;
      taken       <= taken_nxt;
    end
  end

  function automatic void link_we_nxt_q_clear();
  endfunction

`ifdef PC_LINK_EN
  logic link_we_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      link_we_q   <= 1'b0;
      link_addr_q <= '0;
    end else begin
      link_we_q   <= link_we_nxt;
      link_addr_q <= link_addr_nxt;
    end
  end

  assign link_we   = link_we_q;
  assign link_addr = link_addr_q;
`else
  logic unused_link;

  assign link_addr_q = '0;
  assign unused_link = ^{link_we_nxt, link_addr_nxt};
  assign link_we     = 1'b0;
  assign link_addr   = '0;
`endif

  assign is_branch = (state == ST_WAIT);
  assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed vector table, hand-written multi-cycle sequences,
// then randomized traffic against a behavioural model of the sequencing rules.
module tb_pc_seq_unit;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int BR_WAIT = 2;
  localparam int HALT    = 2**ADDR_W - 2;
  localparam int MASK    = 2**ADDR_W - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable_fetch, enable_mem, stall;
  logic [31:0]       ir;
  logic [DATA_W-1:0] rs_t, rs_a;
  logic [ADDR_W-1:0] address, link_addr;
  logic              is_branch, taken, halted, link_we;

  int checks = 0;
  int errors = 0;

  int m_addr, m_wait, m_laddr;
  bit m_halt, m_taken, m_lwe;

  pc_seq_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BR_WAIT(BR_WAIT), .HALT_ADDR(HALT)) dut (
    .clk(clk), .rst(rst), .enable_fetch(enable_fetch), .enable_mem(enable_mem),
    .stall(stall), .ir(ir), .rs_t(rs_t), .rs_a(rs_a), .address(address),
    .is_branch(is_branch), .taken(taken), .halted(halted), .link_we(link_we),
    .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       ir;
    logic [31:0]       rt;
    logic [31:0]       ra;
    logic              ef;
    logic              em;
    logic              st;
    logic [ADDR_W-1:0] e_addr;
    logic              e_taken;
    logic              e_br;
    logic              e_halt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] NOP   = 32'h0;
  localparam logic [31:0] JR_IR = {1'b0, 6'b100101, 25'd0};

  function automatic logic [31:0] br_ir(input logic bne, input logic [13:0] imm);
    return {1'b0, 6'b100110, 10'd0, bne, imm};
  endfunction

  function automatic logic [31:0] jmp_ir(input logic jal, input logic [23:0] imm);
    return {1'b0, 6'b100100, jal, imm};
  endfunction

  // Reference: a branch waits BR_WAIT advancing cycles, then resolves on that cycle's operands.
  task automatic model_resolve();
    int off;
    bit cond;
    off  = int'($signed(ir[13:0])) * 2;
    cond = ir[14] ? (rs_t != rs_a) : (rs_t == rs_a);
    if (cond) begin
      m_addr  = (m_addr + off) & MASK;
      m_taken = 1;
    end else begin
      m_addr = (m_addr + 1) & MASK;
    end
  endtask

  task automatic model_step();
    int old;
    if (rst) begin
      m_addr = MASK; m_halt = 0; m_wait = 0; m_taken = 0; m_lwe = 0; m_laddr = 0;
    end else begin
      m_taken = 0;
      m_lwe   = 0;
      if (enable_fetch && enable_mem && !stall && !m_halt) begin
        old = m_addr;
        if (m_addr == HALT) begin
          m_halt = 1;
        end else if (m_wait > 0) begin
          if (m_wait == 1) model_resolve();
          m_wait--;
        end else begin
          case (ir[30:25])
            6'b100110: if (BR_WAIT == 0) model_resolve(); else m_wait = BR_WAIT;
            6'b100100: begin
              m_addr  = (m_addr + int'($signed(ir[23:0])) * 2) & MASK;
              m_taken = 1;
`ifdef PC_LINK_EN
              if (ir[24]) begin
                m_lwe   = 1;
                m_laddr = (old + 1) & MASK;
              end
`endif
            end
            6'b100101: begin
              m_addr  = int'(rs_a[ADDR_W-1:0]);
              m_taken = 1;
            end
            default: m_addr = (m_addr + 1) & MASK;
          endcase
        end
      end
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic [31:0] i, input logic [31:0] rt,
                                input logic [31:0] ra, input logic ef, input logic em,
                                input logic st);
    rst = r; ir = i; rs_t = rt; rs_a = ra;
    enable_fetch = ef; enable_mem = em; stall = st;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_output(input string name, input logic [ADDR_W-1:0] ea, input logic et,
                              input logic eb, input logic eh, input logic elw,
                              input logic [ADDR_W-1:0] ela);
    checks++;
    if (address !== ea || taken !== et || is_branch !== eb || halted !== eh ||
        link_we !== elw || link_addr !== ela) begin
      errors++;
      $display("[TB] FAIL %s: got addr=%h taken=%b br=%b halt=%b lwe=%b laddr=%h, want addr=%h taken=%b br=%b halt=%b lwe=%b laddr=%h",
               name, address, taken, is_branch, halted, link_we, link_addr,
               ea, et, eb, eh, elw, ela);
    end
  endtask

  task automatic add_vec(input logic [31:0] i, input logic [31:0] rt, input logic [31:0] ra,
                         input logic ef, input logic em, input logic st,
                         input logic [ADDR_W-1:0] ea, input logic et, input logic eb,
                         input logic eh);
    vec_t v;
    v.ir = i; v.rt = rt; v.ra = ra; v.ef = ef; v.em = em; v.st = st;
    v.e_addr = ea; v.e_taken = et; v.e_br = eb; v.e_halt = eh;
    vecs.push_back(v);
  endtask

  initial begin
    logic [ADDR_W-1:0] jal_laddr;
    logic              jal_lwe;

    add_vec(NOP, 0, 0, 1, 1, 0, 10'h000, 0, 0, 0);
    add_vec(NOP, 0, 0, 1, 1, 0, 10'h001, 0, 0, 0);
    add_vec(NOP, 0, 0, 1, 1, 0, 10'h002, 0, 0, 0);
    add_vec(NOP, 0, 0, 1, 1, 0, 10'h003, 0, 0, 0);
    add_vec(NOP, 0, 0, 0, 1, 0, 10'h003, 0, 0, 0);
    add_vec(NOP, 0, 0, 1, 1, 1, 10'h003, 0, 0, 0);
    add_vec(JR_IR, 0, 32'h10, 1, 1, 0, 10'h010, 1, 0, 0);
    add_vec(br_ir(0, 14'd5), 7, 7, 1, 1, 0, 10'h010, 0, 1, 0);
    add_vec(br_ir(0, 14'd5), 7, 7, 1, 1, 0, 10'h010, 0, 1, 0);
    add_vec(br_ir(0, 14'd5), 7, 7, 1, 1, 0, 10'h01A, 1, 0, 0);
    add_vec(JR_IR, 0, 32'h10, 1, 1, 0, 10'h010, 1, 0, 0);
    add_vec(br_ir(1, 14'd5), 7, 7, 1, 1, 0, 10'h010, 0, 1, 0);
    add_vec(br_ir(1, 14'd5), 7, 7, 1, 1, 0, 10'h010, 0, 1, 0);
    add_vec(br_ir(1, 14'd5), 7, 7, 1, 1, 0, 10'h011, 0, 0, 0);
    add_vec(JR_IR, 0, 32'h10, 1, 1, 0, 10'h010, 1, 0, 0);
    add_vec(br_ir(0, 14'd5), 1, 2, 1, 1, 0, 10'h010, 0, 1, 0);
    add_vec(br_ir(0, 14'd5), 1, 2, 1, 1, 0, 10'h010, 0, 1, 0);
    for (int k = 0; k < 3; k++) add_vec(br_ir(0, 14'd5), 1, 2, 1, 1, 1, 10'h010, 0, 1, 0);
    add_vec(br_ir(0, 14'd5), 7, 7, 1, 1, 0, 10'h01A, 1, 0, 0);
    add_vec(JR_IR, 0, 32'h0, 1, 1, 0, 10'h000, 1, 0, 0);
    add_vec(jmp_ir(0, 24'hFFFFFF), 0, 0, 1, 1, 0, 10'h3FE, 1, 0, 0);
    for (int k = 0; k < 6; k++) add_vec(NOP, 0, 0, 1, 1, 0, 10'h3FE, 0, 0, 1);

    apply_stimulus(1, NOP, 0, 0, 0, 0, 0);
    apply_stimulus(1, NOP, 0, 0, 0, 0, 0);
    check_output("reset", 10'h3FF, 0, 0, 0, 0, 10'h000);

    foreach (vecs[k]) begin
      apply_stimulus(0, vecs[k].ir, vecs[k].rt, vecs[k].ra, vecs[k].ef, vecs[k].em, vecs[k].st);
      check_output($sformatf("vec%0d", k), vecs[k].e_addr, vecs[k].e_taken, vecs[k].e_br,
                   vecs[k].e_halt, 0, 10'h000);
    end

    apply_stimulus(1, NOP, 0, 0, 1, 1, 0);
    check_output("reset_from_halt", 10'h3FF, 0, 0, 0, 0, 10'h000);

    // Reset in the middle of a branch wait must drop the branch entirely.
    apply_stimulus(0, br_ir(0, 14'd5), 7, 7, 1, 1, 0);
    check_output("wait_enter", 10'h3FF, 0, 1, 0, 0, 10'h000);
    apply_stimulus(1, br_ir(0, 14'd5), 7, 7, 1, 1, 0);
    check_output("reset_mid_wait", 10'h3FF, 0, 0, 0, 0, 10'h000);
    apply_stimulus(0, NOP, 7, 7, 1, 1, 0);
    check_output("after_mid_wait", 10'h000, 0, 0, 0, 0, 10'h000);

`ifdef PC_LINK_EN
    jal_lwe = 1; jal_laddr = 10'h021;
`else
    jal_lwe = 0; jal_laddr = 10'h000;
`endif
    apply_stimulus(0, JR_IR, 0, 32'h20, 1, 1, 0);
    check_output("jr_020", 10'h020, 1, 0, 0, 0, 10'h000);
    apply_stimulus(0, jmp_ir(1, 24'd3), 0, 0, 1, 1, 0);
    check_output("jal", 10'h026, 1, 0, 0, jal_lwe, jal_laddr);
    apply_stimulus(0, NOP, 0, 0, 1, 1, 0);
    check_output("jal_after", 10'h027, 0, 0, 0, 0, jal_laddr);

    apply_stimulus(1, NOP, 0, 0, 1, 1, 0);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ri;
      logic [31:0] rt, ra;
      int sel;
      ri  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 3)       ri[30:25] = 6'b100110;
      else if (sel == 3) ri[30:25] = 6'b100100;
      else if (sel == 4) ri[30:25] = 6'b100101;
      rt = $urandom_range(0, 3);
      ra = (sel == 4) ? $urandom : $urandom_range(0, 3);
      apply_stimulus(($urandom_range(0, 99) == 0), ri, rt, ra,
                     ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0),
                     ($urandom_range(0, 9) == 0));
      check_output("random", ADDR_W'(m_addr), m_taken, (m_wait > 0), m_halt, m_lwe,
                   ADDR_W'(m_laddr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
